// File: rtl/rgb_led_pwm.sv
// Multi-channel LED PWM driver with prescaler, frame-synchronous shadow
// registers for glitch-free duty updates, and optional frame-based blinking.
module rgb_led_pwm #(
   parameter int unsigned NCH      = 6,
   parameter int unsigned PWM_BITS = 8,
   parameter int unsigned PRE_W    = 16
) (
   input  logic                    axi_aclk,
   input  logic                    axi_aresetn,
   input  logic [NCH*PWM_BITS-1:0] duty,
   input  logic [NCH-1:0]          ch_en,
   input  logic [PRE_W-1:0]        prescale,
   input  logic                    blink_en,
   input  logic [7:0]              blink_period,
   input  logic                    update,
   output logic [NCH-1:0]          led_out,
   output logic                    frame_start,
   output logic                    update_pending
);

   // Counter tops out one below all-ones so an all-ones duty stays high across the wrap.
   localparam logic [PWM_BITS-1:0] CntMax = {{(PWM_BITS-1){1'b1}}, 1'b0};

   logic [PRE_W-1:0]        pcnt_q, pcnt_d;
   logic [PWM_BITS-1:0]     cnt_q, cnt_d;
   logic                    tick;
   logic                    wrap;
   logic                    frame_start_q;

   logic [NCH*PWM_BITS-1:0] shadow_duty_q, shadow_duty_d;
   logic [NCH-1:0]          shadow_en_q, shadow_en_d;
   logic [NCH*PWM_BITS-1:0] act_duty_q, act_duty_d;
   logic [NCH-1:0]          act_en_q, act_en_d;
   logic                    pending_q, pending_d;

   logic [7:0]              fcnt_q, fcnt_d;
   logic                    phase_q, phase_d;

   logic [NCH-1:0]          led_q, led_d;

   // Prescaler and PWM counter.
   always_comb begin
      tick   = (pcnt_q >= prescale);
      wrap   = 1'b0;
      pcnt_d = pcnt_q + PRE_W'(1);
      cnt_d  = cnt_q;
      if (tick) begin
         pcnt_d = '0;
         if (cnt_q == CntMax) begin
            cnt_d = '0;
            wrap  = 1'b1;
         end else begin
            cnt_d = cnt_q + PWM_BITS'(1);
         end
      end
   end

   // Shadow capture and frame-boundary application.
   always_comb begin
      shadow_duty_d = shadow_duty_q;
      shadow_en_d   = shadow_en_q;
      act_duty_d    = act_duty_q;
      act_en_d      = act_en_q;
      pending_d     = pending_q;
      if (wrap && pending_q) begin
         act_duty_d = shadow_duty_q;
         act_en_d   = shadow_en_q;
         pending_d  = 1'b0;
      end
      // A coincident update re-arms pending with the fresh inputs.
      if (update) begin
         shadow_duty_d = duty;
         shadow_en_d   = ch_en;
         pending_d     = 1'b1;
      end
   end

   // Blink phase advances on frame boundaries.
   always_comb begin
      fcnt_d  = fcnt_q;
      phase_d = phase_q;
      if (!blink_en) begin
         fcnt_d  = '0;
         phase_d = 1'b0;
      end else if (wrap) begin
         if (fcnt_q == blink_period) begin
            fcnt_d  = '0;
            phase_d = ~phase_q;
         end else begin
            fcnt_d = fcnt_q + 8'd1;
         end
      end
   end

   always_comb begin
      led_d = '0;
      for (int i = 0; i < NCH; i++) begin
         led_d[i] = act_en_q[i] & ~phase_q &
                    (cnt_q < act_duty_q[i*PWM_BITS +: PWM_BITS]);
      end
   end

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         pcnt_q        <= '0;
         cnt_q         <= '0;
         frame_start_q <= 1'b0;
         shadow_duty_q <= '0;
         shadow_en_q   <= '0;
         act_duty_q    <= '0;
         act_en_q      <= '0;
         pending_q     <= 1'b0;
         fcnt_q        <= '0;
         phase_q       <= 1'b0;
         led_q         <= '0;
      end else begin
         pcnt_q        <= pcnt_d;
         cnt_q         <= cnt_d;
         frame_start_q <= wrap;
         shadow_duty_q <= shadow_duty_d;
         shadow_en_q   <= shadow_en_d;
         act_duty_q    <= act_duty_d;
         act_en_q      <= act_en_d;
         pending_q     <= pending_d;
         fcnt_q        <= fcnt_d;
         phase_q       <= phase_d;
         led_q         <= led_d;
      end
   end

   assign led_out        = led_q;
   assign frame_start    = frame_start_q;
   assign update_pending = pending_q;

endmodule

// File: tb/tb_rgb_led_pwm.sv
// Scoreboard bench for rgb_led_pwm: expected frame lengths and per-channel
// high counts are queued with each stimulus and checked as frames complete.
module tb_rgb_led_pwm;

   localparam int NCH   = 6;
   localparam int PW    = 8;
   localparam int PRE_W = 16;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [NCH*PW-1:0]    duty;
   logic [NCH-1:0]       ch_en;
   logic [PRE_W-1:0]     prescale;
   logic                 blink_en;
   logic [7:0]           blink_period;
   logic                 update;
   logic [NCH-1:0]       led_out;
   logic                 frame_start;
   logic                 update_pending;

   rgb_led_pwm #(
      .NCH      (NCH),
      .PWM_BITS (PW),
      .PRE_W    (PRE_W)
   ) dut (
      .axi_aclk       (clk),
      .axi_aresetn    (rst_n),
      .duty           (duty),
      .ch_en          (ch_en),
      .prescale       (prescale),
      .blink_en       (blink_en),
      .blink_period   (blink_period),
      .update         (update),
      .led_out        (led_out),
      .frame_start    (frame_start),
      .update_pending (update_pending)
   );

   always #5 clk = ~clk;

   typedef struct {
      string tag;
      int    val;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   meas_len;
   int   meas_high[NCH];

   task automatic check(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic sb_push(input string tag, input int val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb_q.push_back(e);
   endtask

   task automatic sb_check(input int obs);
      exp_t e;
      if (sb_q.size() == 0) begin
         check("sb_empty", obs, -1);
      end else begin
         e = sb_q.pop_front();
         check(e.tag, obs, e.val);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_duty(input int ch, input logic [7:0] val);
      duty[ch*PW +: PW] = val;
   endtask

   task automatic pulse_update();
      update = 1'b1;
      step();
      update = 1'b0;
   endtask

   task automatic wait_frame();
      bit seen = 1'b0;
      for (int i = 0; i < 5000 && !seen; i++) begin
         step();
         if (frame_start) seen = 1'b1;
      end
      if (!seen) check("frame_timeout", 0, 1);
   endtask

   // Called at a frame_start sample; counts through the next frame_start
   // sample inclusive. Optionally pulses update with a new ch0 duty mid-frame.
   task automatic measure_frame(input int upd_at, input logic [7:0] upd_duty);
      bit seen = 1'b0;
      meas_len = 0;
      for (int c = 0; c < NCH; c++) meas_high[c] = 0;
      for (int i = 0; i < 5000 && !seen; i++) begin
         step();
         meas_len++;
         for (int c = 0; c < NCH; c++) meas_high[c] += int'(led_out[c]);
         if (frame_start) seen = 1'b1;
         if (meas_len == upd_at) begin
            set_duty(0, upd_duty);
            update = 1'b1;
         end else begin
            update = 1'b0;
         end
      end
      update = 1'b0;
      if (!seen) check("measure_timeout", 0, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int bad;
      int n;
      duty         = '0;
      ch_en        = '0;
      prescale     = '0;
      blink_en     = 1'b0;
      blink_period = '0;
      update       = 1'b0;
      rst_n        = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_led", int'(led_out), 0);
      check("rst_fs", int'(frame_start), 0);
      check("rst_pend", int'(update_pending), 0);
      rst_n = 1'b1;

      // Basic duty 64 on ch0, prescale 0.
      set_duty(0, 8'd64);
      ch_en = 6'b000001;
      pulse_update();
      check("pend_set", int'(update_pending), 1);
      bad = 0;
      n   = 0;
      while (!frame_start && n < 1000) begin
         if (!update_pending) bad++;
         step();
         n++;
      end
      check("pend_hold", bad, 0);
      check("fs_seen", int'(frame_start), 1);
      check("pend_clr", int'(update_pending), 0);
      for (int f = 0; f < 2; f++) begin
         sb_push("d64_len", 255);
         sb_push("d64_high", 64);
         measure_frame(-1, 8'd0);
         sb_check(meas_len);
         sb_check(meas_high[0]);
      end

      // Extreme duties: 0 stays low, 255 stays high across wraps.
      set_duty(1, 8'd0);
      set_duty(2, 8'd255);
      ch_en = '1;
      pulse_update();
      wait_frame();
      for (int f = 0; f < 3; f++) begin
         sb_push("ext_len", 255);
         sb_push("ext_ch0", 64);
         sb_push("ext_ch1", 0);
         sb_push("ext_ch2", 255);
         measure_frame(-1, 8'd0);
         sb_check(meas_len);
         sb_check(meas_high[0]);
         sb_check(meas_high[1]);
         sb_check(meas_high[2]);
      end

      // Prescale 3: 1020-clock frames, mid-frame update deferred to next frame.
      prescale = 16'd3;
      set_duty(0, 8'd128);
      pulse_update();
      wait_frame();
      sb_push("p3_len", 1020);
      sb_push("p3_high", 512);
      measure_frame(300, 8'd32);
      sb_check(meas_len);
      sb_check(meas_high[0]);
      sb_push("p3_new_len", 1020);
      sb_push("p3_new_high", 128);
      measure_frame(-1, 8'd0);
      sb_check(meas_len);
      sb_check(meas_high[0]);

      // Blink with period 1: two frames on, two off.
      prescale     = 16'd0;
      set_duty(0, 8'd255);
      ch_en        = 6'b000001;
      blink_period = 8'd1;
      pulse_update();
      wait_frame();
      blink_en = 1'b1;
      sb_push("blink_f1", 255);
      sb_push("blink_f2", 255);
      sb_push("blink_f3", 0);
      for (int f = 0; f < 3; f++) begin
         measure_frame(-1, 8'd0);
         sb_check(meas_high[0]);
      end
      blink_en = 1'b0;
      step();
      step();
      check("blink_off", int'(led_out[0]), 1);

      // Update on the boundary clock with a prior pending value.
      wait_frame();
      repeat (10) step();
      set_duty(0, 8'd10);
      pulse_update();
      check("dbl_pend1", int'(update_pending), 1);
      repeat (254 - 11) step();
      set_duty(0, 8'd200);
      update = 1'b1;
      step();
      update = 1'b0;
      check("dbl_fs", int'(frame_start), 1);
      check("dbl_pend2", int'(update_pending), 1);
      sb_push("dbl_old", 10);
      measure_frame(-1, 8'd0);
      sb_check(meas_high[0]);
      check("dbl_pend_clr", int'(update_pending), 0);
      sb_push("dbl_new", 200);
      measure_frame(-1, 8'd0);
      sb_check(meas_high[0]);

      // Reset mid-frame with a pending update.
      repeat (5) step();
      set_duty(0, 8'd100);
      pulse_update();
      check("pre_rst_led", int'(led_out[0]), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_led", int'(led_out), 0);
      check("mid_rst_fs", int'(frame_start), 0);
      check("mid_rst_pend", int'(update_pending), 0);
      step();
      rst_n = 1'b1;
      n   = 0;
      bad = 0;
      while (!frame_start && n < 1000) begin
         step();
         n++;
         bad += int'(led_out != '0);
      end
      check("post_rst_first_fs", n, 255);
      check("post_rst_led_quiet", bad, 0);
      check("post_rst_pend", int'(update_pending), 0);
      sb_push("post_rst_len", 255);
      sb_push("post_rst_high", 0);
      measure_frame(-1, 8'd0);
      sb_check(meas_len);
      sb_check(meas_high[0]);

      check("sb_drained", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rgb_led_pwm.md
RGB_LED_PWM -- requirements
Module: rgb_led_pwm

Interface
REQ-001 SHALL have parameter NCH, default 6, number of LED channels (led1 R/G/B, led2 R/G/B in bit order 0..5).
REQ-002 SHALL have parameter PWM_BITS, default 8, duty and PWM counter width.
REQ-003 SHALL have parameter PRE_W, default 16, prescaler width.
REQ-004 SHALL have one clock and an asynchronous, active-low reset; ports listed below, clock and reset first.
REQ-005 axi_aclk  in  1  sole clock, all state rising-edge.
REQ-006 axi_aresetn  in  1  asynchronous active-low reset.
REQ-007 duty  in  NCH*PWM_BITS  per-channel duty, channel i at bits [i*PWM_BITS +: PWM_BITS], from the register file.
REQ-008 ch_en  in  NCH  per-channel enable.
REQ-009 prescale  in  PRE_W  PWM tick every prescale+1 clocks.
REQ-010 blink_en  in  1  enables blink gating.
REQ-011 blink_period  in  8  blink half-period in frames, minus 1.
REQ-012 update  in  1  single-cycle strobe; captures duty/ch_en into shadow.
REQ-013 led_out  out  NCH  registered PWM outputs.
REQ-014 frame_start  out  1  one-cycle pulse at each PWM frame boundary.
REQ-015 update_pending  out  1  high while shadow values await application.

Function
REQ-016 Prescaler pcnt: increments each clock; when pcnt >= prescale, tick=1 and pcnt<=0 next clock; prescale=0 gives tick every clock; lowering prescale below pcnt wraps on the next clock.
REQ-017 PWM counter cnt: advances on tick only, range 0..2^PWM_BITS-2 (0..254 default); on tick at max it wraps to 0.
REQ-018 Frame boundary: the tick on which cnt wraps to 0; frame_start SHALL be 1 for the clock after that tick, else 0.
REQ-019 update=1: duty and ch_en captured into shadow registers that clock; update_pending<=1.
REQ-020 At frame boundary with update_pending=1: shadow copied to active registers; update_pending<=0, unless update=1 same clock, in which case active takes the old shadow, shadow takes the new inputs, update_pending stays 1.
REQ-021 Active registers SHALL change only at frame boundaries; duty/ch_en inputs have no other effect.
REQ-022 Blink: when blink_en=1, frame counter fcnt counts frame boundaries; at boundary with fcnt==blink_period, phase toggles and fcnt<=0; blink_period=0 toggles every frame.
REQ-023 blink_en=0: phase<=0 and fcnt<=0 next clock.
REQ-024 led_out[i] <= ch_en_act[i] & ~phase & (cnt < duty_act[i]), registered, one clock after cnt.
REQ-025 duty_act=0 gives led_out constant 0; duty_act=255 (all ones) gives constant 1 while enabled, no glitch at wrap.
REQ-026 Duty d in 1..254 gives exactly d high ticks per 255-tick frame.

Reset
REQ-027 axi_aresetn=0 SHALL asynchronously clear pcnt, cnt, fcnt, phase, shadow and active registers, led_out, frame_start, update_pending to 0.
REQ-028 Reset mid-frame SHALL discard pending updates; after release, counting restarts at pcnt=0, cnt=0, first tick on the clock after release plus prescale.

Verification
REQ-029 Reset, prescale=0, duty ch0=64, update pulse -> update_pending=1 until first frame_start, then led_out[0] high 64 of every 255 clocks.
REQ-030 duty ch1=0 and ch2=255, ch_en=all ones, update -> led_out[1]=0 and led_out[2]=1 continuously across 3 frames including wraps.
REQ-031 prescale=3, duty=128 -> frame 1020 clocks, led_out high 512 clocks; change duty mid-frame with update -> output unchanged until next frame_start.
REQ-032 blink_en=1, blink_period=1, duty=255 -> led_out toggles every 2 frames; blink_en=0 -> led_out returns high within 2 clocks.
REQ-033 update asserted on frame-boundary clock with prior pending -> old shadow applied, new value applied one frame later, update_pending high for that extra frame.
REQ-034 Assert axi_aresetn=0 mid-frame with update_pending=1 -> all outputs 0 immediately; after release, led_out stays 0 (duty_act=0) with no update.
